// File: rtl/imm_enc_pkg.sv
// rtl/imm_enc_pkg.sv - shared constants and helpers for the immediate encoder
//
// Holds the format selector codes, error codes, the canonical NOP word and a
// sign-run helper used by the range checks.

package imm_enc_pkg;

   typedef enum logic [2:0] {
      EXT_I = 3'b000,
      EXT_U = 3'b001,
      EXT_S = 3'b010,
      EXT_B = 3'b011,
      EXT_J = 3'b100
   } extop_e;

   typedef enum logic [1:0] {
      ERR_OK    = 2'd0,
      ERR_RANGE = 2'd1,
      ERR_ALIGN = 2'd2,
      ERR_BADOP = 2'd3
   } err_e;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // True when v[31:msb] are all equal, i.e. v is a sign extension of
   // v[msb:0] and therefore fits a (msb+1)-bit signed field.
   function automatic logic sign_run_ok(input logic [31:0] v, input int unsigned msb);
      logic [31:0] w_sh;
      w_sh = 32'($signed(v) >>> msb);
      return (w_sh == 32'h0000_0000) || (w_sh == 32'hFFFF_FFFF);
   endfunction

endpackage

// File: rtl/imm_pack.sv
// rtl/imm_pack.sv - combinational immediate packer with range/alignment check
//
// Ports:
//   base  in  32  template instruction; bits outside the immediate fields pass through
//   imm   in  32  signed immediate (byte offset for B/J)
//   extop in  3   format select (I/U/S/B/J, others invalid)
//   instr out 32  base with the immediate fields overwritten
//   err   out 2   OK / RANGE / ALIGN / BADOP, BADOP highest priority

module imm_pack
   import imm_enc_pkg::*;
(
   input  logic [31:0] base,
   input  logic [31:0] imm,
   input  logic [2:0]  extop,
   output logic [31:0] instr,
   output logic [1:0]  err
);

   logic w_range;
   logic w_align;
   logic w_bad;

   always_comb begin
      instr   = base;
      w_range = 1'b0;
      w_align = 1'b0;
      w_bad   = 1'b0;
      case (extop)
         EXT_I: begin
            instr[31:20] = imm[11:0];
            w_range      = !sign_run_ok(imm, 11);
         end
         EXT_S: begin
            instr[31:25] = imm[11:5];
            instr[11:7]  = imm[4:0];
            w_range      = !sign_run_ok(imm, 11);
         end
         EXT_U: begin
            instr[31:12] = imm[31:12];
            w_align      = (imm[11:0] != 12'h000);
         end
         EXT_B: begin
            instr[31]    = imm[12];
            instr[30:25] = imm[10:5];
            instr[11:8]  = imm[4:1];
            instr[7]     = imm[11];
            w_align      = imm[0];
            w_range      = !sign_run_ok(imm, 12);
         end
         EXT_J: begin
            instr[31]    = imm[20];
            instr[30:21] = imm[10:1];
            instr[20]    = imm[11];
            instr[19:12] = imm[19:12];
            w_align      = imm[0];
            w_range      = !sign_run_ok(imm, 20);
         end
         default: begin
            // Unknown format: leave the template untouched.
            w_bad = 1'b1;
         end
      endcase
   end

   always_comb begin
      err = ERR_OK;
      if (w_bad) begin
         err = ERR_BADOP;
      end else if (w_align) begin
         err = ERR_ALIGN;
      end else if (w_range) begin
         err = ERR_RANGE;
      end
   end

endmodule

// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - streaming RISC-V immediate encoder with address counter
//
// Optional feature macro: IMM_STRICT_EN (errored words are emitted as NOP).
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid/ready  request handshake; in_base, in_imm, in_extop request payload
//   out_valid/ready encoded word handshake
//   out_instr       encoded instruction
//   out_err         0 OK, 1 RANGE, 2 ALIGN, 3 BADOP
//   out_addr        instruction-memory address of out_instr
//   err_cnt         saturating count of accepted requests that had an error

module imm_encoder #(
   parameter int unsigned        ADDR_W    = 32,
   parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_base,
   input  logic [31:0]       in_imm,
   input  logic [2:0]        in_extop,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [1:0]        out_err,
   output logic [ADDR_W-1:0] out_addr,
   output logic [15:0]       err_cnt
);
   import imm_enc_pkg::*;

   localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

   logic [31:0]       w_pack_instr;
   logic [1:0]        w_pack_err;
   logic [31:0]       w_instr_out;
   logic              w_in_hs;
   logic              w_out_hs;

   logic              r_valid;
   logic [31:0]       r_instr;
   logic [1:0]        r_err;
   logic [ADDR_W-1:0] r_addr;
   logic [15:0]       r_err_cnt;

   imm_pack u_pack (
      .base  (in_base),
      .imm   (in_imm),
      .extop (in_extop),
      .instr (w_pack_instr),
      .err   (w_pack_err)
   );

`ifdef IMM_STRICT_EN
   assign w_instr_out = (w_pack_err != ERR_OK) ? NOP_INSTR : w_pack_instr;
`else
   assign w_instr_out = w_pack_instr;
`endif

   // Single output stage: a new word may enter whenever the current one
   // leaves in the same cycle, so continuous ready gives one word per cycle.
   assign in_ready = !r_valid || out_ready;
   assign w_in_hs  = in_valid && in_ready;
   assign w_out_hs = r_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid   <= 1'b0;
         r_instr   <= 32'h0000_0000;
         r_err     <= ERR_OK;
         r_addr    <= BASE_ADDR;
         r_err_cnt <= 16'h0000;
      end else begin
         // The address belongs to the word being presented, so it moves on
         // only once that word is taken; wrap is silent.
         if (w_out_hs) begin
            r_addr <= r_addr + ADDR_STEP;
         end
         if (w_in_hs) begin
            r_valid <= 1'b1;
            r_instr <= w_instr_out;
            r_err   <= w_pack_err;
         end else if (w_out_hs) begin
            r_valid <= 1'b0;
         end
         if (w_in_hs && (w_pack_err != ERR_OK) && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'h0001;
         end
      end
   end

   assign out_valid = r_valid;
   assign out_instr = r_instr;
   assign out_err   = r_err;
   assign out_addr  = r_addr;
   assign err_cnt   = r_err_cnt;

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the immediate generator: packs a 32-bit signed immediate into the I/U/S/B/J bit positions of a RISC-V instruction word, on top of a base word that supplies opcode/rd/rs/funct fields.
- Checks that the immediate is representable in the chosen format.
- Emits encoded words with a sequential instruction-memory address over a valid/ready stream.
- Used by the test framework to build instruction memory images.

Parameters:
- ADDR_W, 32, width of the output address counter.
- BASE_ADDR, 32'h0000_0000, first output address; the counter resets to this value.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_base  in  32  template instruction; immediate fields are overwritten.
- in_imm  in  32  signed immediate (byte offset for B/J).
- in_extop  in  3  format: 000 I, 001 U, 010 S, 011 B, 100 J.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  consumer ready.
- out_instr  out  32  encoded instruction.
- out_err  out  2  error code: 0 OK, 1 RANGE, 2 ALIGN, 3 BADOP.
- out_addr  out  ADDR_W  address of out_instr.
- err_cnt  out  16  saturating count of accepted requests with out_err != 0.

Behaviour:
- Reset values: out_valid=0, out_instr=0, out_err=0, out_addr=BASE_ADDR, err_cnt=0.
- One output register stage; latency 1 cycle from input handshake to out_valid.
- in_ready = !out_valid || out_ready, which gives full throughput (one word per cycle under continuous ready).
- Register load: on input handshake, load out_instr/out_err and set out_valid=1.
- Register clear: on output handshake with no new input, clear out_valid.
- Output hold: while out_valid && !out_ready, out_instr, out_err and out_addr stay stable.
- out_addr advances by +4 on each output handshake. It wraps modulo 2^ADDR_W with no flag.
- Packing rules; bits not listed pass through from in_base:
  - I: [31:20]=imm[11:0]. RANGE if imm[31:11] not all equal.
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0]. RANGE as for I.
  - U: [31:12]=imm[31:12]. ALIGN if imm[11:0]!=0.
  - B: [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1]. ALIGN if imm[0]=1. RANGE if imm[31:12] not all equal.
  - J: [31]=imm[20], [19:12]=imm[19:12], [20]=imm[11], [30:21]=imm[10:1]. ALIGN if imm[0]=1. RANGE if imm[31:20] not all equal.
  - extop 101–111: BADOP; out_instr = in_base unchanged.
- Error priority: BADOP > ALIGN > RANGE.
- Errored words are still emitted and still consume an address.
- err_cnt increments on input handshake with a nonzero error and saturates at 16'hFFFF.
- Reset mid-transfer: a pending word is discarded, the counter returns to BASE_ADDR, and no output handshake is reported that cycle.

Optional Feature:
- Macro IMM_STRICT_EN.
- When defined: any word with out_err != 0 has out_instr replaced by NOP 32'h0000_0013. out_err is still reported.
- When undefined: the immediate is truncated to the format fields exactly as the packing rules above produce.

Decomposition:
- Package imm_enc_pkg holds:
  - extop constants (EXT_I, EXT_U, EXT_S, EXT_B, EXT_J);
  - error codes (ERR_OK, ERR_RANGE, ERR_ALIGN, ERR_BADOP);
  - NOP_INSTR = 32'h0000_0013.
- Sub-module imm_pack: purely combinational packing plus range/alignment check. Inputs base, imm, extop; outputs instr, err.
- imm_encoder holds the handshake register, the address counter and err_cnt.

Test Plan:
- I format: base 0x00000093, imm 0xFFFFFFFF, extop 000 → out_instr 0xFFF00093, err 0, out_addr 0x0.
- B format: base 0x00000063, imm 0x00000010, extop 011 → out_instr 0x00000863, err 0. Same with imm 0x11 → err 2 (ALIGN), err_cnt 1.
- J format: base 0x0000006F, imm 0x00000800, extop 100 → out_instr 0x0010006F, err 0.
- Range error: I format, base 0x00000093, imm 0x00000800 → err 1. out_instr 0x80000093 without IMM_STRICT_EN, 0x00000013 with it. extop 111 → err 3, out_instr = base.
- Backpressure: two requests back to back, out_ready low for 3 cycles → first word and out_addr 0x0 held stable, in_ready 0. Then ready high → words at 0x0 and 0x4 on consecutive cycles.
- Reset: assert rst while out_valid=1 and out_addr=0x8 → next cycle out_valid 0, out_addr BASE_ADDR, err_cnt 0.
